// File: rtl/op_stack_if.sv
// rtl/op_stack_if.sv - command and spill/fill memory bus for op_stack
interface op_stack_if #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 10
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [2:0]               cmd_op;
  logic [WIDTH-1:0]         cmd_arg;
  logic [$clog2(DEPTH)-1:0] cmd_sel;
  logic                     mem_req;
  logic                     mem_wr;
  logic [ADDR_WIDTH-1:0]    mem_addr;
  logic [WIDTH-1:0]         mem_wdata;
  logic [WIDTH-1:0]         mem_rdata;
  logic                     mem_ack;

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, cmd_sel, mem_rdata, mem_ack,
    output cmd_ready, mem_req, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output cmd_valid, cmd_op, cmd_arg, cmd_sel, mem_rdata, mem_ack,
    input  cmd_ready, mem_req, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/op_stack.sv
// rtl/op_stack.sv - register operand stack with memory spill/fill
module op_stack #(
  parameter int                    WIDTH       = 16,
  parameter int                    DEPTH       = 16,
  parameter int                    SPILL_DEPTH = 256,
  parameter int                    ADDR_WIDTH  = 10,
  parameter logic [ADDR_WIDTH-1:0] SPILL_BASE  = 10'h100
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  op_stack_if.slave                                  bus,
  output logic [WIDTH-1:0]                           top0,
  output logic [WIDTH-1:0]                           top1,
  output logic [$clog2(DEPTH+SPILL_DEPTH+1)-1:0]     depth,
  output logic                                       err_overflow,
  output logic                                       err_underflow
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(SPILL_DEPTH + 1);
  localparam int DW = $clog2(DEPTH + SPILL_DEPTH + 1);
  localparam logic [CW-1:0] REG_FULL   = CW'(DEPTH);
  localparam logic [SW-1:0] SPILL_FULL = SW'(SPILL_DEPTH);

  localparam logic [2:0] OP_PUSH = 3'd1, OP_POP = 3'd2, OP_REPLACE = 3'd3,
                         OP_POP_REPLACE = 3'd4, OP_DUP = 3'd5, OP_SWAP = 3'd6,
                         OP_CLEAR = 3'd7;

  typedef enum logic [1:0] {IDLE, SPILL, FILL} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] entries [DEPTH];
  logic [CW-1:0]    reg_cnt;
  logic [SW-1:0]    spill_cnt;
  logic [WIDTH-1:0] push_hold;
  logic [WIDTH-1:0] push_val;
  logic do_push, do_pop, do_rep, do_swap, do_clear, do_fill;
  logic spill_done, go_spill, go_fill, set_uf, set_of;

  assign bus.cmd_ready = (state == IDLE);
  assign top0  = entries[0];
  assign top1  = entries[1];
  assign depth = DW'(reg_cnt) + DW'(spill_cnt);

  // State register; reset also drops mem_req through the datapath block below
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Command decode, precondition checks and spill/fill sequencing
  always_comb begin
    state_n    = state;
    push_val   = bus.cmd_arg;
    do_push    = 1'b0;
    do_pop     = 1'b0;
    do_rep     = 1'b0;
    do_swap    = 1'b0;
    do_clear   = 1'b0;
    do_fill    = 1'b0;
    spill_done = 1'b0;
    go_spill   = 1'b0;
    go_fill    = 1'b0;
    set_uf     = 1'b0;
    set_of     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd_op)
            OP_PUSH, OP_DUP: begin
              if (bus.cmd_op == OP_DUP) push_val = entries[bus.cmd_sel];
              if (bus.cmd_op == OP_DUP && CW'(bus.cmd_sel) >= reg_cnt) set_uf = 1'b1;
              else if (reg_cnt == REG_FULL) begin
                if (spill_cnt == SPILL_FULL) set_of = 1'b1;
                else                         go_spill = 1'b1;
              end else do_push = 1'b1;
            end
            OP_POP: begin
              if (depth == '0) set_uf = 1'b1;
              else             do_pop = 1'b1;
            end
            OP_REPLACE: begin
              if (depth == '0) set_uf = 1'b1;
              else             do_rep = 1'b1;
            end
            OP_POP_REPLACE: begin
              if (depth < DW'(2)) set_uf = 1'b1;
              else begin
                do_pop = 1'b1;
                do_rep = 1'b1;
              end
            end
            OP_SWAP: begin
              if (depth < DW'(2)) set_uf = 1'b1;
              else                do_swap = 1'b1;
            end
            OP_CLEAR: do_clear = 1'b1;
            default: ;
          endcase
          // Only a pop can take the register part below two entries while spilled
          go_fill = do_pop && (reg_cnt <= CW'(2)) && (spill_cnt != '0);
          if (go_spill)     state_n = SPILL;
          else if (go_fill) state_n = FILL;
        end
      end
      SPILL: begin
        if (bus.mem_req && bus.mem_ack) begin
          do_push    = 1'b1;
          push_val   = push_hold;
          spill_done = 1'b1;
          state_n    = IDLE;
        end
      end
      FILL: begin
        if (!bus.mem_req) go_fill = 1'b1;
        else if (bus.mem_ack) begin
          do_fill = 1'b1;
          if (!(reg_cnt == '0 && spill_cnt > SW'(1))) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Register file, counters, sticky flags and memory request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      reg_cnt       <= '0;
      spill_cnt     <= '0;
      push_hold     <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_wr    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      if (do_clear) begin
        for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
        reg_cnt       <= '0;
        spill_cnt     <= '0;
        err_overflow  <= 1'b0;
        err_underflow <= 1'b0;
      end else begin
        if (set_uf) err_underflow <= 1'b1;
        if (set_of) err_overflow  <= 1'b1;
        if (do_push) begin
          for (int i = DEPTH - 1; i > 0; i--) entries[i] <= entries[i-1];
          entries[0] <= push_val;
          if (reg_cnt != REG_FULL) reg_cnt <= reg_cnt + CW'(1);
        end
        if (do_pop) begin
          for (int i = 0; i < DEPTH - 1; i++) entries[i] <= entries[i+1];
          entries[DEPTH-1] <= '0;
          reg_cnt <= reg_cnt - CW'(1);
        end
        // Placed after the pop shift so POP_REPLACE lands arg on the new top
        if (do_rep) entries[0] <= bus.cmd_arg;
        if (do_swap) begin
          entries[0] <= entries[1];
          entries[1] <= entries[0];
        end
        if (do_fill) begin
          for (int i = 0; i < DEPTH; i++)
            if (CW'(i) == reg_cnt) entries[i] <= bus.mem_rdata;
          reg_cnt   <= reg_cnt + CW'(1);
          spill_cnt <= spill_cnt - SW'(1);
        end
        if (spill_done) spill_cnt <= spill_cnt + SW'(1);
      end
      if (go_spill) begin
        bus.mem_req   <= 1'b1;
        bus.mem_wr    <= 1'b1;
        bus.mem_addr  <= (SPILL_BASE + ADDR_WIDTH'(spill_cnt)) << 1;
        bus.mem_wdata <= entries[DEPTH-1];
        push_hold     <= push_val;
      end else if (go_fill) begin
        bus.mem_req  <= 1'b1;
        bus.mem_wr   <= 1'b0;
        bus.mem_addr <= (SPILL_BASE + ADDR_WIDTH'(spill_cnt - SW'(1))) << 1;
      end else if (spill_done || do_fill) begin
        bus.mem_req <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_op_stack.sv
// tb/tb_op_stack.sv - randomized and directed checks of op_stack against a logical-stack model
module tb_op_stack;
  localparam int W = 16, D = 4, SD = 2, AW = 10;
  localparam logic [2:0] NOP = 0, PUSH = 1, POP = 2, REPL = 3, POPR = 4, DUP = 5, SWAP = 6, CLR = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  op_stack_if #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW)) bus ();
  logic [W-1:0] top0, top1;
  logic [2:0]   depth;
  logic         err_overflow, err_underflow;

  op_stack #(.WIDTH(W), .DEPTH(D), .SPILL_DEPTH(SD), .ADDR_WIDTH(AW), .SPILL_BASE(10'h100)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .top0(top0), .top1(top1), .depth(depth),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  int errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // memory responder: acks after lat extra cycles, stores spills, returns them on fills
  int lat = 0, wcnt = 0, wr_cnt = 0, rd_cnt = 0;
  logic [AW-1:0] last_wr_addr = '0, last_rd_addr = '0;
  logic [W-1:0]  last_wr_data = '0;
  logic [W-1:0]  mem [int];

  initial begin
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_req && !bus.mem_ack) begin
        if (wcnt >= lat) begin
          bus.mem_ack = 1'b1;
          wcnt = 0;
          if (bus.mem_wr) begin
            mem[int'(bus.mem_addr)] = bus.mem_wdata;
            wr_cnt++;
            last_wr_addr = bus.mem_addr;
            last_wr_data = bus.mem_wdata;
          end else begin
            bus.mem_rdata = mem.exists(int'(bus.mem_addr)) ? mem[int'(bus.mem_addr)] : '0;
            rd_cnt++;
            last_rd_addr = bus.mem_addr;
          end
        end else wcnt++;
      end else begin
        bus.mem_ack = 1'b0;
        wcnt = 0;
      end
    end
  end

  // reference model: the whole logical stack, top at index 0
  logic [W-1:0] stk[$];
  int mreg = 0, exp_wr = 0, exp_rd = 0, exp_wr_addr = 0, exp_wr_data = 0, exp_rd_addr = 0;
  bit m_uf = 0, m_of = 0;

  task automatic model_refill();
    int spill = stk.size() - mreg;
    if (mreg < 2 && spill > 0) begin
      exp_rd++;
      exp_rd_addr = (256 + spill - 1) * 2;
      mreg++;
    end
  endtask

  task automatic model(input logic [2:0] op, input logic [W-1:0] arg, input int sel);
    int spill = stk.size() - mreg;
    logic [W-1:0] v;
    case (op)
      PUSH, DUP: begin
        if (op == DUP && sel >= mreg) m_uf = 1;
        else if (mreg == D && spill == SD) m_of = 1;
        else begin
          v = (op == DUP) ? stk[sel] : arg;
          if (mreg == D) begin
            exp_wr++;
            exp_wr_addr = (256 + spill) * 2;
            exp_wr_data = int'(stk[D-1]);
          end else mreg++;
          stk.push_front(v);
        end
      end
      POP: if (stk.size() == 0) m_uf = 1;
           else begin void'(stk.pop_front()); mreg--; model_refill(); end
      REPL: if (stk.size() < 1) m_uf = 1; else stk[0] = arg;
      POPR: if (stk.size() < 2) m_uf = 1;
            else begin void'(stk.pop_front()); stk[0] = arg; mreg--; model_refill(); end
      SWAP: if (stk.size() < 2) m_uf = 1;
            else begin v = stk[0]; stk[0] = stk[1]; stk[1] = v; end
      CLR: begin stk.delete(); mreg = 0; m_uf = 0; m_of = 0; end
      default: ;
    endcase
  endtask

  task automatic verify(input string tag);
    chk({tag, " top0"}, top0, stk.size() > 0 ? stk[0] : '0);
    chk({tag, " top1"}, top1, stk.size() > 1 ? stk[1] : '0);
    chk({tag, " depth"}, depth, stk.size());
    chk({tag, " err_underflow"}, err_underflow, m_uf);
    chk({tag, " err_overflow"}, err_overflow, m_of);
    chk({tag, " spill writes"}, wr_cnt, exp_wr);
    chk({tag, " fill reads"}, rd_cnt, exp_rd);
    if (exp_wr > 0) begin
      chk({tag, " spill addr"}, last_wr_addr, exp_wr_addr);
      chk({tag, " spill data"}, last_wr_data, exp_wr_data);
    end
    if (exp_rd > 0) chk({tag, " fill addr"}, last_rd_addr, exp_rd_addr);
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [W-1:0] arg, input int sel, output int busy);
    int t = 0;
    @(negedge clk);
    while (!bus.cmd_ready && t < 100) begin t++; @(negedge clk); end
    if (t >= 100) chk("ready before command", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_arg = arg;
    bus.cmd_sel = 2'(sel);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    busy = 0;
    while (!bus.cmd_ready && busy < 100) begin busy++; @(negedge clk); end
    if (busy >= 100) chk("command completion", bus.cmd_ready, 1);
    model(op, arg, sel);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int busy, r;
    logic [2:0] op;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = '0;
    bus.cmd_arg = '0;
    bus.cmd_sel = '0;
    repeat (3) @(negedge clk);
    chk("reset top0", top0, 0);
    chk("reset top1", top1, 0);
    chk("reset depth", depth, 0);
    chk("reset err_overflow", err_overflow, 0);
    chk("reset err_underflow", err_underflow, 0);
    chk("reset mem_req", bus.mem_req, 0);
    chk("reset mem_wr", bus.mem_wr, 0);
    chk("reset mem_addr", bus.mem_addr, 0);
    chk("reset mem_wdata", bus.mem_wdata, 0);
    chk("reset cmd_ready", bus.cmd_ready, 1);
    rst_n = 1'b1;

    run_cmd(PUSH, 5, 0, busy);  verify("basic push5");
    run_cmd(PUSH, 7, 0, busy);  verify("basic push7");
    run_cmd(POPR, 12, 0, busy); verify("basic pop_replace");
    chk("basic top0 const", top0, 12);
    chk("basic depth const", depth, 1);

    run_cmd(CLR, 0, 0, busy);
    lat = 2;
    for (int v = 1; v <= 5; v++) begin run_cmd(PUSH, W'(v), 0, busy); verify("spill push"); end
    chk("spill busy cycles", busy, 3);
    chk("spill addr const", last_wr_addr, 'h200);
    chk("spill data const", last_wr_data, 1);
    chk("spill depth const", depth, 5);
    chk("spill top0 const", top0, 5);

    for (int k = 0; k < 3; k++) begin run_cmd(POP, 0, 0, busy); verify("fill pop"); end
    chk("fill addr const", last_rd_addr, 'h200);
    chk("fill top1 const", top1, 1);
    chk("fill depth const", depth, 2);

    lat = 0;
    run_cmd(CLR, 0, 0, busy);
    run_cmd(POP, 0, 0, busy); verify("underflow pop");
    chk("underflow flag const", err_underflow, 1);
    run_cmd(CLR, 0, 0, busy);
    for (int v = 1; v <= 7; v++) begin run_cmd(PUSH, W'(v * 3), 0, busy); verify("overflow push"); end
    chk("overflow flag const", err_overflow, 1);
    chk("overflow depth const", depth, 6);
    run_cmd(CLR, 0, 0, busy); verify("clear flags");
    chk("clear flags const", {err_overflow, err_underflow}, 0);

    run_cmd(PUSH, 9, 0, busy);
    run_cmd(PUSH, 3, 0, busy);
    run_cmd(DUP, 0, 1, busy);  verify("dup sel1");
    chk("dup top0 const", top0, 9);
    chk("dup top1 const", top1, 3);
    run_cmd(SWAP, 0, 0, busy); verify("swap");
    chk("swap top0 const", top0, 3);
    chk("swap top1 const", top1, 9);
    run_cmd(DUP, 0, 3, busy);  verify("dup sel3");
    chk("dup sel3 underflow const", err_underflow, 1);

    run_cmd(CLR, 0, 0, busy);
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = PUSH; bus.cmd_arg = 16'h1111;
    @(negedge clk);
    chk("back-to-back ready", bus.cmd_ready, 1);
    bus.cmd_arg = 16'h2222;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    model(PUSH, 16'h1111, 0);
    model(PUSH, 16'h2222, 0);
    verify("back-to-back");

    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      op = (r < 35) ? PUSH : (r < 55) ? POP : (r < 62) ? REPL : (r < 72) ? POPR :
           (r < 80) ? DUP : (r < 88) ? SWAP : (r < 90) ? CLR : NOP;
      lat = $urandom_range(0, 2);
      run_cmd(op, W'($urandom), $urandom_range(0, 3), busy);
      verify("random");
    end

    lat = 50;
    run_cmd(CLR, 0, 0, busy);
    for (int v = 1; v <= 4; v++) run_cmd(PUSH, W'(v), 0, busy);
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = PUSH; bus.cmd_arg = 16'h5555;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid-spill mem_req", bus.mem_req, 1);
    chk("mid-spill mem_wr", bus.mem_wr, 1);
    #2 rst_n = 1'b0;
    #1 chk("async reset mem_req", bus.mem_req, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset depth", depth, 0);
    chk("post-reset cmd_ready", bus.cmd_ready, 1);
    chk("post-reset top0", top0, 0);
    chk("post-reset spill writes", wr_cnt, exp_wr);
    lat = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/op_stack.md
# op_stack

Parametrised operand stack for the next-generation stack CPU. It replaces the fixed 16-entry register stack with a WIDTH×DEPTH register file that exposes the top two entries to the ALU. When the register part overflows, the stack spills its bottom entries to data memory, and it refills them on underflow through a req/ack handshake. Sticky overflow and underflow flags catch bad programs. It sits between the CPU decode/ALU path and the data-memory arbiter.

## Interface
- WIDTH, 16, entry width in bits
- DEPTH, 16, register entries (≥4)
- SPILL_DEPTH, 256, memory-backed entries (≥1)
- ADDR_WIDTH, 10, memory address width
- SPILL_BASE, 10'h100, word index of the first spill slot
- clk  in  1  clock; single clock domain, all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  high when FSM is IDLE
- cmd_op  in  3  0 NOP, 1 PUSH, 2 POP, 3 REPLACE, 4 POP_REPLACE, 5 DUP, 6 SWAP, 7 CLEAR
- cmd_arg  in  WIDTH  data for PUSH/REPLACE/POP_REPLACE
- cmd_sel  in  $clog2(DEPTH)  entry index for DUP
- top0, top1  out  WIDTH  entry[0], entry[1] (registered)
- depth  out  $clog2(DEPTH+SPILL_DEPTH+1)  logical depth = reg_cnt+spill_cnt
- err_overflow, err_underflow  out  1  sticky error flags
- mem_req  out  1  spill/fill request
- mem_wr  out  1  1 spill (write), 0 fill (read)
- mem_addr  out  ADDR_WIDTH  (SPILL_BASE+slot)<<1, byte address
- mem_wdata  out  WIDTH  spilled entry
- mem_rdata  in  WIDTH  fill data, valid with mem_ack
- mem_ack  in  1  one-cycle completion pulse

## Operation
- Reset:
  - All entries, reg_cnt, spill_cnt, top0, top1, depth, err flags, mem_req, mem_wr, mem_addr and mem_wdata are 0.
  - FSM is IDLE, so cmd_ready=1.
- A command executes on the edge where cmd_valid & cmd_ready.
- Command effects:
  - PUSH: entry[i+1]<=entry[i], entry[0]<=arg, reg_cnt+1.
  - POP: entry[i]<=entry[i+1], entry[DEPTH-1]<=0, reg_cnt−1.
  - REPLACE: entry[0]<=arg; needs depth≥1.
  - POP_REPLACE: POP, then entry[0]<=arg. Used for binary ALU ops; needs depth≥2.
  - DUP: PUSH of the pre-edge entry[sel]; needs sel<reg_cnt.
  - SWAP: exchanges entry[0] and entry[1]; needs depth≥2.
  - CLEAR: all counts and entries to 0; error flags cleared.
- Underflow:
  - Precondition unmet → command dropped, err_underflow<=1.
  - A plain POP at depth=0 also underflows.
- Overflow:
  - PUSH/DUP when reg_cnt=DEPTH and spill_cnt=SPILL_DEPTH → dropped, err_overflow<=1.
- Spill:
  - PUSH/DUP when reg_cnt=DEPTH and spill_cnt<SPILL_DEPTH: the command is latched and FSM→SPILL.
  - On the acceptance edge, mem_req=1, mem_wr=1, mem_addr=slot spill_cnt, mem_wdata=entry[DEPTH-1]. These are held stable until mem_ack.
  - On the mem_ack edge: spill_cnt+1, and the latched push executes (bottom entry discarded, reg_cnt stays DEPTH). mem_req<=0, FSM→IDLE.
- Fill:
  - Triggered when an executed command leaves reg_cnt<2 with spill_cnt>0. FSM→FILL on that same edge.
  - mem_req=1, mem_wr=0, mem_addr=slot spill_cnt−1.
  - On the mem_ack edge: entry[reg_cnt]<=mem_rdata, reg_cnt+1, spill_cnt−1.
  - Repeats FILL while reg_cnt<2 and spill_cnt>0; otherwise → IDLE.
- Invariant: spill_cnt>0 implies reg_cnt≥2 whenever cmd_ready=1.
- Outside SPILL/FILL, mem_req is 0. mem_ack while mem_req=0 is ignored.
- Error flags clear only on CLEAR or reset. Commands continue executing while the flags are set.

## Timing
- Non-memory commands: result visible on top0/top1/depth 1 cycle after the accepting edge. Back-to-back commands are accepted every cycle.
- Spill PUSH:
  - cmd_ready=0 from the cycle after acceptance through the mem_ack cycle.
  - Minimum 2 cycles, with mem_ack on the first req cycle.
  - New top0 is visible after the ack edge.
- Fill: 1+N cycles per entry, where N is the mem_ack wait.
- mem_req asserts at most 1 cycle after the triggering edge. It deasserts on the ack edge; it never pulses twice per slot.
- rst_n low mid-SPILL/FILL: mem_req drops immediately (asynchronous). No partial count update.

## Test plan
- Basic operations, reset then PUSH 5, PUSH 7, POP_REPLACE arg 12 → top0=12, depth=1, no error flags.
- Spill, DEPTH=4, mem_ack 2 cycles after req:
  - PUSH 1..5 → one write, mem_addr=0x200, mem_wdata=1.
  - cmd_ready low for 3 cycles.
  - Ends with depth=5, top0=5.
- Fill:
  - Continue the spill case with POP ×3 → after the third POP, reg_cnt=1.
  - Fill read at mem_addr=0x200 with rdata=1 → top1=1, depth=2.
- Underflow/overflow:
  - POP at depth 0 → err_underflow=1, depth stays 0.
  - With SPILL_DEPTH=1, DEPTH=4, push 6 values → err_overflow=1, depth=5.
  - CLEAR → both flags 0.
- DUP/SWAP: stack [3,9] → DUP sel=1 → top0=9, top1=3. SWAP → top0=3, top1=9. DUP sel=3 at reg_cnt=3 → err_underflow.
- Reset mid-operation: assert rst_n low during SPILL with mem_req=1 → mem_req=0 in the same cycle; after release, depth=0 and cmd_ready=1.
